// File: rtl/vx_wb_pkg.sv
// Shared types for the writeback sink: index-width helpers and the buffered beat format.
// The beat struct is sized from the package defaults, so top-level overrides must match them.
package vx_wb_pkg;

    function automatic int nw_bits(input int num_warps);
        return (num_warps > 1) ? $clog2(num_warps) : 1;
    endfunction

    function automatic int nr_bits(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

    localparam int WB_NUM_WARPS   = 4;
    localparam int WB_NUM_THREADS = 4;
    localparam int WB_NUM_REGS    = 64;
    localparam int WB_NW_BITS     = nw_bits(WB_NUM_WARPS);
    localparam int WB_NR_BITS     = nr_bits(WB_NUM_REGS);

    typedef struct packed {
        logic [WB_NW_BITS-1:0]       wid;
        logic [31:0]                 PC;
        logic [WB_NUM_THREADS-1:0]   tmask;
        logic [WB_NR_BITS-1:0]       rd;
        logic [WB_NUM_THREADS*32-1:0] data;
        logic                        eop;
    } wb_beat_t;

endpackage

// File: rtl/vx_writeback_sink_if.sv
// Writeback beat handshake between the writeback arbiter (master) and the sink (slave).
interface vx_writeback_sink_if
    import vx_wb_pkg::*;
#(
    parameter int NW_BITS     = WB_NW_BITS,
    parameter int NR_BITS     = WB_NR_BITS,
    parameter int NUM_THREADS = WB_NUM_THREADS
);
    logic                     wb_valid;
    logic                     wb_ready;
    logic [NW_BITS-1:0]       wb_wid;
    logic [31:0]              wb_PC;
    logic [NUM_THREADS-1:0]   wb_tmask;
    logic [NR_BITS-1:0]       wb_rd;
    logic [NUM_THREADS*32-1:0] wb_data;
    logic                     wb_eop;

    modport master (
        output wb_valid, wb_wid, wb_PC, wb_tmask, wb_rd, wb_data, wb_eop,
        input  wb_ready
    );

    modport slave (
        input  wb_valid, wb_wid, wb_PC, wb_tmask, wb_rd, wb_data, wb_eop,
        output wb_ready
    );
endinterface

// File: rtl/vx_wb_fifo.sv
// Small synchronous FIFO of writeback beats; push is refused when full even if a pop is
// happening in the same cycle, so freed space becomes visible one cycle later.
module vx_wb_fifo
    import vx_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     push,
    input  wb_beat_t push_data,
    input  logic     pop,
    output wb_beat_t head,
    output logic     full,
    output logic     empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_beat_t          mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vx_writeback_sink.sv
// Writeback consumer: buffers beats, drives the GPR write port and owns the issue scoreboard.
// Optional VX_WB_LAST_VALUE_EN keeps the last thread-0 value per register for debug readout.
module vx_writeback_sink
    import vx_wb_pkg::*;
#(
    parameter int NUM_WARPS   = WB_NUM_WARPS,
    parameter int NUM_THREADS = WB_NUM_THREADS,
    parameter int NUM_REGS    = WB_NUM_REGS,
    parameter int FIFO_DEPTH  = 2,
    localparam int NW_BITS    = nw_bits(NUM_WARPS),
    localparam int NR_BITS    = nr_bits(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    vx_writeback_sink_if.slave        wb,
    output logic [NUM_THREADS-1:0]    gpr_we,
    output logic [NW_BITS-1:0]        gpr_wid,
    output logic [NR_BITS-1:0]        gpr_rd,
    output logic [NUM_THREADS*32-1:0] gpr_data,
    input  logic                      gpr_ready,
    input  logic                      iss_valid,
    input  logic [NW_BITS-1:0]        iss_wid,
    input  logic [NR_BITS-1:0]        iss_rd,
    input  logic [NR_BITS-1:0]        iss_rs1,
    input  logic [NR_BITS-1:0]        iss_rs2,
    input  logic [NR_BITS-1:0]        iss_rs3,
    input  logic                      iss_wb,
    output logic                      iss_ready,
    input  logic [NR_BITS-1:0]        dbg_rd,
    output logic [31:0]               dbg_value
);
    wb_beat_t push_beat;
    wb_beat_t head;
    logic     full;
    logic     empty;
    logic     push;
    logic     pop;

    assign push_beat = '{wid:   wb.wb_wid,
                         PC:    wb.wb_PC,
                         tmask: wb.wb_tmask,
                         rd:    wb.wb_rd,
                         data:  wb.wb_data,
                         eop:   wb.wb_eop};

    assign wb.wb_ready = !full;
    assign push        = wb.wb_valid && !full;
    assign pop         = !empty && gpr_ready;

    vx_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_beat),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign gpr_we   = empty ? '0 : head.tmask;
    assign gpr_wid  = head.wid;
    assign gpr_rd   = head.rd;
    assign gpr_data = head.data;

    logic [NUM_WARPS-1:0][NUM_REGS-1:0] inuse;
    logic release_en;
    logic set_en;
    logic iss_fire;

    assign release_en = pop && head.eop;
    assign iss_fire   = iss_valid && iss_ready;
    assign set_en     = iss_fire && iss_wb && (iss_rd != '0);

    // Hazard check looks only at registered bits; a release this cycle is seen next cycle.
    always_comb begin
        iss_ready = !(inuse[iss_wid][iss_rs1] |
                      inuse[iss_wid][iss_rs2] |
                      inuse[iss_wid][iss_rs3] |
                      (iss_wb & inuse[iss_wid][iss_rd]));
    end

    // Set is applied after clear so a collision on one entry leaves it marked.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inuse <= '0;
        end else begin
            if (release_en) inuse[head.wid][head.rd] <= 1'b0;
            if (set_en)     inuse[iss_wid][iss_rd]   <= 1'b1;
        end
    end

`ifdef VX_WB_LAST_VALUE_EN
    logic [31:0] last_value [NUM_REGS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) last_value[i] <= '0;
        end else if (pop && gpr_we[0]) begin
            last_value[head.rd] <= head.data[31:0];
        end
    end

    assign dbg_value = last_value[dbg_rd];

    logic unused_bits;
    assign unused_bits = ^head.PC;
`else
    assign dbg_value = '0;

    logic unused_bits;
    assign unused_bits = ^{head.PC, dbg_rd};
`endif

    a_release_marked: assert property (@(posedge clk) disable iff (!reset_n)
        release_en |-> inuse[head.wid][head.rd]);

    a_valid_held: assert property (@(posedge clk) disable iff (!reset_n)
        (wb.wb_valid && !wb.wb_ready) |=> wb.wb_valid);

endmodule

// File: tb/tb_vx_writeback_sink.sv
// Directed bench for vx_writeback_sink: handshake, FIFO ordering, scoreboard set/clear, reset.
module tb_vx_writeback_sink;
    import vx_wb_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   gpr_we;
    logic [1:0]   gpr_wid;
    logic [5:0]   gpr_rd;
    logic [127:0] gpr_data;
    logic         gpr_ready;
    logic         iss_valid;
    logic [1:0]   iss_wid;
    logic [5:0]   iss_rd, iss_rs1, iss_rs2, iss_rs3;
    logic         iss_wb;
    logic         iss_ready;
    logic [5:0]   dbg_rd;
    logic [31:0]  dbg_value;
    logic [31:0]  exp_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vx_writeback_sink_if #(.NW_BITS(2), .NR_BITS(6), .NUM_THREADS(4)) wb_if ();

    vx_writeback_sink dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wb        (wb_if),
        .gpr_we    (gpr_we),
        .gpr_wid   (gpr_wid),
        .gpr_rd    (gpr_rd),
        .gpr_data  (gpr_data),
        .gpr_ready (gpr_ready),
        .iss_valid (iss_valid),
        .iss_wid   (iss_wid),
        .iss_rd    (iss_rd),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rs3   (iss_rs3),
        .iss_wb    (iss_wb),
        .iss_ready (iss_ready),
        .dbg_rd    (dbg_rd),
        .dbg_value (dbg_value)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_iss();
        iss_valid = 0; iss_wid = 0; iss_rd = 0; iss_wb = 0;
        iss_rs1 = 0; iss_rs2 = 0; iss_rs3 = 0;
    endtask

    task automatic idle_wb();
        wb_if.wb_valid = 0; wb_if.wb_wid = 0; wb_if.wb_PC = 0; wb_if.wb_tmask = 0;
        wb_if.wb_rd = 0; wb_if.wb_data = 0; wb_if.wb_eop = 0;
    endtask

    task automatic offer(input logic [1:0] wid, input logic [5:0] rd,
                         input logic [3:0] tmask, input logic eop, input logic [31:0] d0);
        wb_if.wb_valid = 1; wb_if.wb_wid = wid; wb_if.wb_rd = rd; wb_if.wb_tmask = tmask;
        wb_if.wb_eop = eop; wb_if.wb_PC = 32'h8000_0000 | {26'd0, rd};
        wb_if.wb_data = {d0 + 32'd3, d0 + 32'd2, d0 + 32'd1, d0};
    endtask

    task automatic issue(input logic [1:0] wid, input logic [5:0] rd);
        idle_iss();
        iss_valid = 1; iss_wid = wid; iss_rd = rd; iss_wb = 1;
    endtask

    // Reads one scoreboard bit through the hazard output (rs1 = reg, all else 0).
    task automatic probe(input logic [1:0] wid, input logic [5:0] rs);
        idle_iss();
        iss_wid = wid; iss_rs1 = rs;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 0; gpr_ready = 0; dbg_rd = 0;
        idle_iss(); idle_wb();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (gpr_we !== 4'h0) begin errors++; $display("FAIL reset_gpr_we: got %h expected 0", gpr_we); end
        checks++; if (wb_if.wb_ready !== 1'b1) begin errors++; $display("FAIL reset_wb_ready: got %b expected 1", wb_if.wb_ready); end
        reset_n = 1;
        tick();
        probe(2'd0, 6'd1);
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL reset_iss_ready: got %b expected 1", iss_ready); end
        checks++; if (dbg_value !== 32'h0) begin errors++; $display("FAIL reset_dbg_value: got %h expected 0", dbg_value); end
    endtask

    task automatic test_hazard();
        issue(2'd1, 6'd5);
        #1;
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL hazard_issue_ready: got %b expected 1", iss_ready); end
        tick();
        probe(2'd1, 6'd5);
        checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL hazard_rs1_blocked: got %b expected 0", iss_ready); end
        gpr_ready = 1;
        offer(2'd1, 6'd5, 4'hF, 1'b1, 32'hA5);
        tick();
        idle_wb();
        checks++; if (gpr_we !== 4'hF) begin errors++; $display("FAIL hazard_gpr_we: got %h expected f", gpr_we); end
        checks++; if (gpr_wid !== 2'd1 || gpr_rd !== 6'd5) begin errors++; $display("FAIL hazard_gpr_addr: got wid %0d rd %0d expected 1 5", gpr_wid, gpr_rd); end
        checks++; if (gpr_data[63:32] !== 32'hA6) begin errors++; $display("FAIL hazard_gpr_data: got %h expected a6", gpr_data[63:32]); end
        probe(2'd1, 6'd5);
        checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL hazard_before_pop: got %b expected 0", iss_ready); end
        tick();
        checks++; if (gpr_we !== 4'h0) begin errors++; $display("FAIL hazard_after_pop_we: got %h expected 0", gpr_we); end
        probe(2'd1, 6'd5);
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL hazard_released: got %b expected 1", iss_ready); end
    endtask

    task automatic test_backpressure();
        gpr_ready = 0;
        offer(2'd0, 6'd1, 4'h1, 1'b0, 32'h11);
        tick();
        offer(2'd0, 6'd2, 4'h3, 1'b0, 32'h22);
        tick();
        checks++; if (wb_if.wb_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b expected 0", wb_if.wb_ready); end
        checks++; if (gpr_we !== 4'h1 || gpr_rd !== 6'd1) begin errors++; $display("FAIL bp_head_a: got we %h rd %0d expected 1 1", gpr_we, gpr_rd); end
        offer(2'd0, 6'd3, 4'h7, 1'b0, 32'h33);
        tick();
        checks++; if (gpr_rd !== 6'd1 || gpr_data[31:0] !== 32'h11) begin errors++; $display("FAIL bp_head_stable: got rd %0d data %h expected 1 11", gpr_rd, gpr_data[31:0]); end
        gpr_ready = 1;
        #1;
        checks++; if (wb_if.wb_ready !== 1'b0) begin errors++; $display("FAIL bp_no_passthrough: got %b expected 0", wb_if.wb_ready); end
        tick();
        checks++; if (wb_if.wb_ready !== 1'b1 || gpr_rd !== 6'd2 || gpr_we !== 4'h3) begin errors++; $display("FAIL bp_pop_a: got ready %b rd %0d we %h expected 1 2 3", wb_if.wb_ready, gpr_rd, gpr_we); end
        tick();
        idle_wb();
        checks++; if (gpr_rd !== 6'd3 || gpr_we !== 4'h7) begin errors++; $display("FAIL bp_pop_b: got rd %0d we %h expected 3 7", gpr_rd, gpr_we); end
        tick();
        checks++; if (gpr_we !== 4'h0) begin errors++; $display("FAIL bp_drained: got %h expected 0", gpr_we); end
    endtask

    task automatic test_multi_beat();
        issue(2'd0, 6'd7);
        tick();
        idle_iss();
        gpr_ready = 1;
        offer(2'd0, 6'd7, 4'hF, 1'b0, 32'h70);
        tick();
        offer(2'd0, 6'd7, 4'hF, 1'b1, 32'h71);
        tick();
        idle_wb();
        checks++; if (gpr_data[31:0] !== 32'h71) begin errors++; $display("FAIL mb_second_head: got %h expected 71", gpr_data[31:0]); end
        probe(2'd0, 6'd7);
        checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL mb_held_after_first: got %b expected 0", iss_ready); end
        tick();
        probe(2'd0, 6'd7);
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL mb_cleared_on_eop: got %b expected 1", iss_ready); end
    endtask

    task automatic test_same_cycle();
        issue(2'd2, 6'd9);
        tick();
        idle_iss();
        gpr_ready = 1;
        offer(2'd2, 6'd9, 4'hF, 1'b1, 32'h90);
        tick();
        idle_wb();
        issue(2'd2, 6'd3);
        #1;
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sc_issue_ready: got %b expected 1", iss_ready); end
        tick();
        probe(2'd2, 6'd3);
        checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL sc_set_rd3: got %b expected 0", iss_ready); end
        probe(2'd2, 6'd9);
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sc_clear_rd9: got %b expected 1", iss_ready); end
        issue(2'd2, 6'd0);
        tick();
        probe(2'd2, 6'd0);
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sc_rd0_unmarked: got %b expected 1", iss_ready); end
    endtask

    task automatic test_last_value();
`ifdef VX_WB_LAST_VALUE_EN
        exp_dbg = 32'h1;
`else
        exp_dbg = 32'h0;
`endif
        idle_iss();
        gpr_ready = 1;
        offer(2'd0, 6'd10, 4'hF, 1'b0, 32'h1);
        tick();
        idle_wb();
        tick();
        dbg_rd = 6'd10;
        #1;
        checks++; if (dbg_value !== exp_dbg) begin errors++; $display("FAIL lv_rd10: got %h expected %h", dbg_value, exp_dbg); end
        offer(2'd0, 6'd10, 4'h0, 1'b0, 32'h2);
        tick();
        checks++; if (gpr_we !== 4'h0) begin errors++; $display("FAIL lv_tmask0_we: got %h expected 0", gpr_we); end
        offer(2'd1, 6'd11, 4'h1, 1'b0, 32'h3);
        tick();
        idle_wb();
        checks++; if (gpr_rd !== 6'd11 || gpr_we !== 4'h1) begin errors++; $display("FAIL lv_tmask0_popped: got rd %0d we %h expected 11 1", gpr_rd, gpr_we); end
        tick();
        checks++; if (dbg_value !== exp_dbg) begin errors++; $display("FAIL lv_tmask0_no_write: got %h expected %h", dbg_value, exp_dbg); end
    endtask

    task automatic test_reset_mid();
        gpr_ready = 0;
        issue(2'd3, 6'd4);
        tick();
        idle_iss();
        offer(2'd3, 6'd4, 4'hF, 1'b1, 32'h40);
        tick();
        offer(2'd3, 6'd4, 4'hF, 1'b1, 32'h41);
        tick();
        idle_wb();
        checks++; if (gpr_we !== 4'hF) begin errors++; $display("FAIL rm_buffered: got %h expected f", gpr_we); end
        probe(2'd3, 6'd4);
        checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL rm_bit_set: got %b expected 0", iss_ready); end
        reset_n = 0;
        #1;
        checks++; if (gpr_we !== 4'h0 || wb_if.wb_ready !== 1'b1) begin errors++; $display("FAIL rm_async: got we %h ready %b expected 0 1", gpr_we, wb_if.wb_ready); end
        probe(2'd3, 6'd4);
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL rm_bit_cleared: got %b expected 1", iss_ready); end
        probe(2'd2, 6'd3);
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL rm_other_cleared: got %b expected 1", iss_ready); end
        tick();
        reset_n = 1;
        gpr_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (gpr_we !== 4'h0) begin errors++; $display("FAIL rm_no_write_%0d: got %h expected 0", i, gpr_we); end
        end
    endtask

    initial begin
        test_reset();
        test_hazard();
        test_backpressure();
        test_multi_beat();
        test_same_cycle();
        test_last_value();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vx_writeback_sink.md
Name: vx_writeback_sink

Overview:
- Consumer end of the writeback interface; receives committed writeback beats from the writeback arbiter/pipe register.
- Buffers beats, drives the GPR write port, and releases scoreboard entries on end-of-packet.
- Also hosts the per-warp register in-use scoreboard that gates issue. Sits between the writeback stage and the register file / issue stage.

Parameters:
- NUM_WARPS, 4, warps per core; NW_BITS = clog2(NUM_WARPS), min 1.
- NUM_THREADS, 4, threads per warp.
- NUM_REGS, 64, architectural registers per warp (int + fp); NR_BITS = clog2(NUM_REGS).
- FIFO_DEPTH, 2, writeback buffer entries; power of 2, at least 2.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- wb_valid  in  1  writeback beat valid.
- wb_ready  out  1  beat accepted when wb_valid && wb_ready.
- wb_wid  in  NW_BITS  warp id.
- wb_PC  in  32  instruction PC (debug only).
- wb_tmask  in  NUM_THREADS  active thread mask.
- wb_rd  in  NR_BITS  destination register.
- wb_data  in  NUM_THREADS*32  per-thread result.
- wb_eop  in  1  last beat of the instruction.
- gpr_we  out  NUM_THREADS  per-thread write enable.
- gpr_wid  out  NW_BITS  write warp.
- gpr_rd  out  NR_BITS  write register.
- gpr_data  out  NUM_THREADS*32  write data.
- gpr_ready  in  1  register file accepts the write (bank free).
- iss_valid  in  1  issue request.
- iss_wid  in  NW_BITS  issuing warp.
- iss_rd, iss_rs1, iss_rs2, iss_rs3  in  NR_BITS each  operands.
- iss_wb  in  1  instruction writes rd.
- iss_ready  out  1  no hazard; issue fires on iss_valid && iss_ready.
- dbg_rd  in  NR_BITS  debug register select.
- dbg_value  out  32  debug value.

Behaviour:
- Reset (async, reset_n=0): FIFO empty, in-use bitmap all 0, gpr_we=0, wb_ready=1, iss_ready=1.
- Reset mid-operation discards buffered beats without writing them.
- Accept: wb_ready = !full. No pass-through when full; a pop in the full cycle frees space only in the next cycle.
- Latency: a beat accepted in cycle N is presented on the gpr_* outputs in cycle N+1 at the earliest. FIFO order is preserved.
- Head presentation: gpr_we = head.tmask when the FIFO is non-empty, else 0. The gpr_wid/gpr_rd/gpr_data fields are held stable while gpr_ready=0.
- Pop: the head pops when non-empty && gpr_ready. A beat with tmask=0 still pops and still releases.
- Release: when the popped head has eop=1, clear inuse[wid][rd] in the same cycle. A beat with eop=0 does not release.
- Hazard: iss_ready = !(inuse[iss_wid][rs1] | inuse[rs2] | inuse[rs3] | (iss_wb & inuse[rd])). The check uses registered state only; a same-cycle release does not bypass it.
- Set: on issue fire with iss_wb=1 and iss_rd!=0, set inuse[iss_wid][iss_rd]. Register 0 is never marked.
- Simultaneous set and clear on the same entry: set wins. Set and clear on different entries both apply.
- Width rules: wid and rd index directly with no wrap. The FIFO count is clog2(FIFO_DEPTH)+1 bits, and the pointers wrap modulo FIFO_DEPTH.
- Assertions (sim only): a release of an entry whose inuse bit is 0 is an error; wb_valid must not drop while wb_ready=0.

Optional Feature:
- Macro VX_WB_LAST_VALUE_EN.
- Defined: keep a last_value[NUM_REGS] array of 32-bit registers, written with gpr_data thread 0 on every pop with gpr_we[0]=1. dbg_value = last_value[dbg_rd] (combinational). last_value is reset to 0. It is used to read RISC-V test pass/fail status.
- Undefined: no storage; dbg_value tied to 0.

Decomposition:
- Package vx_wb_pkg holds the NW_BITS/NR_BITS derivation functions and the packed struct wb_beat_t {wid, PC, tmask, rd, data, eop}. The FIFO stores wb_beat_t.
- One sub-module, vx_wb_fifo: a parameterized FIFO_DEPTH synchronous FIFO with full/empty flags and async active-low reset.
- The scoreboard stays inline.

Test Plan:
- Issue wid=1 rd=5 iss_wb=1 -> inuse[1][5]=1. Next-cycle issue wid=1 rs1=5 -> iss_ready=0. Writeback wid=1 rd=5 eop=1 with gpr_ready=1 -> gpr_we=4'hF one cycle after accept, bit clears, iss_ready=1 the following cycle.
- gpr_ready held 0, three beats offered -> first two accepted, wb_ready=0 on the third. Head fields stay stable. gpr_ready=1 -> pops in order, wb_ready returns to 1 one cycle after the first pop.
- Two-beat writeback (eop=0 then 1) to wid=0 rd=7 -> bit stays set after the first pop and clears only on the second.
- Same-cycle issue set of wid=2 rd=3 and release of wid=2 rd=9 -> inuse[2][3]=1, inuse[2][9]=0. Issue with rd=0 -> no bit set.
- reset_n pulsed low with 2 beats buffered and bits set -> gpr_we=0 immediately, wb_ready=1, all iss_ready=1, and no write is issued after release.
- With VX_WB_LAST_VALUE_EN defined: a write of rd=10 with data[0]=32'h1 gives dbg_rd=10 -> dbg_value=32'h1. With it undefined: dbg_value=0.
